ad7264_conv_ctrl: RTL
=====================

// Module: ad7264_conv_ctrl
// PURPOSE
// Conversion sequencer for the AD7264 SPI master suite on AquaTux. Drives the master's ss,
// startSending and DIM inputs, serialises a 16-bit ADC config word, and deserialises the
// DOMA/DOMB streams into two parallel results. Supports single-shot and continuous sampling.
// Runs on the system clock; monitors the master's SCLK through a synchronous edge detector.
// PARAMETERS
// FRAME_BITS  32  received ADC bits per conversion frame (and SCLK rises in SHIFT)
// TX_BITS     16  config bits sent MSB-first at frame start; startSending high only for these
// LEAD_ZEROS  2   leading zero bits in each ADC stream before result MSB
// DATA_BITS   14  result width per channel
// QUIET_CYC   8   Clk cycles with ss low between frames (AD7264 tQUIET)
// TIMEOUT     255 Clk cycles without an SCLK rise, while ss high, before abort
// PORTS
// Clk          in   1  system clock; must be >= 4x SCLK frequency
// resetn       in   1  asynchronous active-low reset
// start        in   1  single-cycle request to begin a conversion (ignored while busy)
// cont         in   1  1 = re-arm automatically after each frame
// cfg          in   16 config word; latched at start and at each continuous re-arm
// sclk         in   1  master SCLK, double-flopped internally, rise = q1 & ~q2
// doma / domb  in   1  master DOMA / DOMB
// spi_ss       out  1  to master ss; 1 = frame active
// spi_start_tx out  1  to master startSending (MOSI tri-state enable)
// spi_dim      out  1  to master DIM
// busy         out  1  1 in any state except IDLE
// done         out  1  one-cycle pulse when results updated
// err          out  1  one-cycle pulse on timeout abort
// result_a/b   out  14 last completed channel A / B results (DATA_BITS wide)
// BEHAVIOUR
// Reset: state IDLE; all outputs 0; shift regs, counters, results cleared. Async assert mid-frame
//  forces spi_ss=0 immediately; no done/err issued.
// States: IDLE -> SETUP -> SHIFT -> TAIL -> QUIET -> (SETUP if cont, else IDLE).
// IDLE: spi_ss=0. start=1 -> latch cfg into tx_sr, SETUP next cycle.
// SETUP: spi_ss=1, spi_dim=tx_sr[15], spi_start_tx=1. Wait first SCLK rise (covers master
//  SS delay register) -> SHIFT, bit_cnt=0.
// SHIFT: per SCLK rise: bit_cnt++, tx_sr<<=1 (zero fill), spi_dim=tx_sr[15]; spi_start_tx=0 once
//  bit_cnt reaches TX_BITS. Rises 2..FRAME_BITS shift doma/domb into rx_a/rx_b (MSB first).
//  bit_cnt==FRAME_BITS -> TAIL.
// TAIL: spi_ss stays 1; next rise shifts final sample (total FRAME_BITS samples, accounting for
//  master RX register latency), then spi_ss=0 -> QUIET.
// Sample n (n=0 first) = ADC bit n; result = samples LEAD_ZEROS..LEAD_ZEROS+DATA_BITS-1.
//  Trailing samples discarded; leading-zero samples not checked.
// QUIET: count QUIET_CYC Clk cycles; on last cycle load result_a/b, pulse done. Results hold
//  until next done; never change mid-frame.
// cont sampled on done cycle: 1 -> re-latch cfg, SETUP next cycle; 0 -> IDLE. cont dropping
//  mid-frame completes current frame.
// start while busy ignored (no queueing); start on done cycle with cont=0 ignored.
// Timeout: in SETUP/SHIFT/TAIL, TIMEOUT Clk cycles since last rise (or SETUP entry) -> spi_ss=0,
//  spi_start_tx=0, err pulse, IDLE; results unchanged; no done.
// bit_cnt width = clog2(FRAME_BITS+1); timeout counter saturates, cleared on each rise.
// TESTING
// 1 single shot cfg=16'hA5C3, ADC model A=00+14'h2ABC, B=00+14'h1357 -> spi_dim bits A5C3 MSB-
//   first on rises 1..16, start_tx high 16 rises, done once, result_a=2ABC, result_b=1357.
// 2 cont=1 for 3 frames, values 0001/3FFF/2000 -> 3 done pulses, spi_ss low exactly QUIET_CYC
//   between frames, results update only at done.
// 3 start pulsed during SHIFT of frame 1 -> ignored; exactly one done; busy falls after QUIET.
// 4 stop SCLK after rise 10 -> err pulse at TIMEOUT cycles, spi_ss=0, results unchanged, IDLE.
// 5 resetn low at rise 20 -> spi_ss=0 same cycle; outputs 0; next start gives clean frame.
// 6 cont cleared mid-frame 2 -> frame 2 completes with done, then IDLE, busy=0.

Source files
------------

// File: rtl/ad7264_conv_ctrl.sv
`timescale 1ns/1ps
// AD7264 conversion sequencer: frames the SPI master (ss/startSending/DIM), shifts out the
// config word and collects the DOMA/DOMB sample streams into two parallel results.
module ad7264_conv_ctrl #(
   parameter int FRAME_BITS = 32,
   parameter int TX_BITS    = 16,
   parameter int LEAD_ZEROS = 2,
   parameter int DATA_BITS  = 14,
   parameter int QUIET_CYC  = 8,
   parameter int TIMEOUT    = 255
) (
   input  logic                 Clk,
   input  logic                 resetn,
   input  logic                 start,
   input  logic                 cont,
   input  logic [TX_BITS-1:0]   cfg,
   input  logic                 sclk,
   input  logic                 doma,
   input  logic                 domb,
   output logic                 spi_ss,
   output logic                 spi_start_tx,
   output logic                 spi_dim,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [DATA_BITS-1:0] result_a,
   output logic [DATA_BITS-1:0] result_b
);
   localparam int CNT_W = $clog2(FRAME_BITS + 1);
   localparam int TO_W  = $clog2(TIMEOUT + 1);
   localparam int Q_W   = $clog2(QUIET_CYC + 1);
   // Leading-zero samples fall off the top, so only the useful window is stored.
   localparam int RX_W  = FRAME_BITS - LEAD_ZEROS;

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, TAIL, QUIET} state_t;

   state_t               state_q, state_d;
   logic                 sclk_s1_q, sclk_s2_q;
   logic [TX_BITS-1:0]   tx_sr_q, tx_sr_d;
   logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
   logic [Q_W-1:0]       quiet_cnt_q, quiet_cnt_d;
   logic [RX_W-1:0]      rx_a_q, rx_a_d, rx_b_q, rx_b_d;
   logic [DATA_BITS-1:0] result_a_q, result_a_d, result_b_q, result_b_d;
   logic                 rise, active;

   assign rise   = sclk_s1_q & ~sclk_s2_q;
   assign active = (state_q == SETUP) || (state_q == SHIFT) || (state_q == TAIL);

   always_comb begin
      state_d      = state_q;
      tx_sr_d      = tx_sr_q;
      bit_cnt_d    = bit_cnt_q;
      to_cnt_d     = to_cnt_q;
      quiet_cnt_d  = quiet_cnt_q;
      rx_a_d       = rx_a_q;
      rx_b_d       = rx_b_q;
      result_a_d   = result_a_q;
      result_b_d   = result_b_q;
      spi_ss       = 1'b0;
      spi_start_tx = 1'b0;
      spi_dim      = 1'b0;
      done         = 1'b0;
      err          = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               tx_sr_d  = cfg;
               to_cnt_d = '0;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            spi_ss       = 1'b1;
            spi_start_tx = 1'b1;
            spi_dim      = tx_sr_q[TX_BITS-1];
            // First rise only absorbs the master's ss delay register.
            if (rise) begin
               bit_cnt_d = '0;
               to_cnt_d  = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            spi_ss       = 1'b1;
            spi_start_tx = (bit_cnt_q < CNT_W'(TX_BITS));
            spi_dim      = tx_sr_q[TX_BITS-1];
            if (rise) begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               tx_sr_d   = {tx_sr_q[TX_BITS-2:0], 1'b0};
               to_cnt_d  = '0;
               // Master RX register lags one rise, so the first rise carries no sample.
               if (bit_cnt_q != '0) begin
                  rx_a_d = {rx_a_q[RX_W-2:0], doma};
                  rx_b_d = {rx_b_q[RX_W-2:0], domb};
               end
               if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) state_d = TAIL;
            end
         end
         TAIL: begin
            spi_ss  = 1'b1;
            spi_dim = tx_sr_q[TX_BITS-1];
            if (rise) begin
               rx_a_d      = {rx_a_q[RX_W-2:0], doma};
               rx_b_d      = {rx_b_q[RX_W-2:0], domb};
               quiet_cnt_d = '0;
               state_d     = QUIET;
            end
         end
         QUIET: begin
            if (quiet_cnt_q == Q_W'(QUIET_CYC - 1)) begin
               done       = 1'b1;
               result_a_d = rx_a_q[RX_W-1 -: DATA_BITS];
               result_b_d = rx_b_q[RX_W-1 -: DATA_BITS];
               if (cont) begin
                  tx_sr_d  = cfg;
                  to_cnt_d = '0;
                  state_d  = SETUP;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               quiet_cnt_d = quiet_cnt_q + Q_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // SCLK watchdog: abort the frame if the master stalls.
      if (active && !rise) begin
         if (to_cnt_q >= TO_W'(TIMEOUT - 1)) begin
            err     = 1'b1;
            state_d = IDLE;
         end
         to_cnt_d = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + TO_W'(1);
      end
   end

   always_ff @(posedge Clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         sclk_s1_q   <= 1'b0;
         sclk_s2_q   <= 1'b0;
         tx_sr_q     <= '0;
         bit_cnt_q   <= '0;
         to_cnt_q    <= '0;
         quiet_cnt_q <= '0;
         rx_a_q      <= '0;
         rx_b_q      <= '0;
         result_a_q  <= '0;
         result_b_q  <= '0;
      end else begin
         state_q     <= state_d;
         sclk_s1_q   <= sclk;
         sclk_s2_q   <= sclk_s1_q;
         tx_sr_q     <= tx_sr_d;
         bit_cnt_q   <= bit_cnt_d;
         to_cnt_q    <= to_cnt_d;
         quiet_cnt_q <= quiet_cnt_d;
         rx_a_q      <= rx_a_d;
         rx_b_q      <= rx_b_d;
         result_a_q  <= result_a_d;
         result_b_q  <= result_b_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign result_a = result_a_q;
   assign result_b = result_b_q;

endmodule
